fetch_pfq: RTL and testbench

- Parametrised successor to the single-slot fetch stage. It owns its own fetch PC and runs ahead of decode, issuing sequential reads to the IFU into a DEPTH-entry prefetch queue.
- On a jump it flushes the queue and redirects fetch. A response still in flight at that point is discarded.
- Sits between the control unit / decode and the IFU. It replaces the stall-coupled fetch, so IFU latency is hidden whenever decode is stalled.

---
 rtl/fetch_pfq.sv | 166 ++++++++++++++++
 tb/tb_fetch_pfq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pfq.sv
// Prefetching fetch stage: owns the fetch PC, keeps one IFU read in flight and buffers DEPTH entries.
// Optional macro FETCH_PFQ_BYPASS_EN presents an error-free response combinationally when the queue is empty.
module fetch_pfq #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter int unsigned            DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP         = '0
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_jump_valid,
  input  logic [ADDR_WIDTH-1:0]  i_jump_addr,
  input  logic                   i_instr_rdy,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  output logic                   o_instr_vld,
  output logic                   o_bus_error,
  output logic                   o_addr_error,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic                   o_rd_cmd,
  input  logic                   i_busy,
  input  logic                   i_instr_vld,
  input  logic [INSTR_WIDTH-1:0] i_instr_dat,
  input  logic                   i_err_align,
  input  logic                   i_err_bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_WIDTH / 8);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic                  drop_q,     drop_d;
  logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic                  rd_cmd_q,   rd_cmd_d;
  logic                  bus_err_q,  bus_err_d;
  logic                  addr_err_q, addr_err_d;

  logic [INSTR_WIDTH-1:0] mem_instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_pc_q    [DEPTH];

  logic outstanding, rsp_live, rsp_err, rsp_ok, space, issue;
  logic head_vld, bypass, push, pop;

  // A response belongs to the live stream only if it was not marked for dropping and no jump overrides it.
  assign outstanding = (state_q == ST_WAIT) | drop_q;
  assign rsp_live    = (state_q == ST_WAIT) && !drop_q && i_instr_vld && !i_jump_valid;
  assign rsp_err     = i_err_align | i_err_bus;
  assign rsp_ok      = rsp_live && !rsp_err;
  assign space       = ({1'b0, count_q} + (CW+1)'(outstanding)) < DEPTH_C;
  assign issue       = (state_q == ST_ISSUE) && !drop_q && !i_busy && space && !i_jump_valid;
  assign head_vld    = (count_q != '0);
`ifdef FETCH_PFQ_BYPASS_EN
  assign bypass      = rsp_ok && !head_vld && i_instr_rdy;
`else
  assign bypass      = 1'b0;
`endif
  assign push        = rsp_ok && !bypass;
  assign pop         = head_vld && i_instr_rdy && !i_jump_valid;

  always_comb begin
    o_instr_vld = head_vld;
    o_instr     = head_vld ? mem_instr_q[rd_ptr_q] : NOP;
    o_instr_pc  = head_vld ? mem_pc_q[rd_ptr_q] : '0;
`ifdef FETCH_PFQ_BYPASS_EN
    if (!head_vld && rsp_ok) begin
      o_instr_vld = 1'b1;
      o_instr     = i_instr_dat;
      o_instr_pc  = addr_q;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    addr_d     = addr_q;
    rd_cmd_d   = 1'b0;
    bus_err_d  = 1'b0;
    addr_err_d = 1'b0;

    if (issue) begin
      addr_d   = pc_q;
      rd_cmd_d = 1'b1;
      pc_d     = pc_q + PC_STEP;
      state_d  = ST_WAIT;
    end

    if (rsp_live) begin
      if (rsp_err) begin
        bus_err_d  = i_err_bus;
        addr_err_d = i_err_align;
        state_d    = ST_HALT;
      end else begin
        state_d = ST_ISSUE;
      end
    end

    if (drop_q && i_instr_vld) drop_d = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    // A response arriving in the jump cycle is already gone, so only a still-pending one needs the drop flag.
    if (i_jump_valid) begin
      pc_d     = i_jump_addr;
      state_d  = ST_ISSUE;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = outstanding && !i_instr_vld;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_ISSUE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      rd_cmd_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      rd_cmd_q   <= rd_cmd_d;
      bus_err_q  <= bus_err_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= i_instr_dat;
      mem_pc_q[wr_ptr_q]    <= addr_q;
    end
  end

  assign o_addr       = addr_q;
  assign o_rd_cmd     = rd_cmd_q;
  assign o_bus_error  = bus_err_q;
  assign o_addr_error = addr_err_q;

endmodule

// File: tb/tb_fetch_pfq.sv
// Directed bench for fetch_pfq with a behavioural IFU (per-address latency and error injection).
module tb_fetch_pfq;

  localparam logic [31:0] NOP_V = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_jump_valid;
  logic [31:0] i_jump_addr;
  logic        i_instr_rdy;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_vld;
  logic        o_bus_error;
  logic        o_addr_error;
  logic [31:0] o_addr;
  logic        o_rd_cmd;
  logic        i_busy;
  logic        i_instr_vld = 1'b0;
  logic [31:0] i_instr_dat = '0;
  logic        i_err_align = 1'b0;
  logic        i_err_bus   = 1'b0;

  fetch_pfq #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h100), .NOP(NOP_V)
  ) dut (
    .clk(clk), .nrst(nrst), .i_jump_valid(i_jump_valid), .i_jump_addr(i_jump_addr),
    .i_instr_rdy(i_instr_rdy), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .o_instr_vld(o_instr_vld), .o_bus_error(o_bus_error), .o_addr_error(o_addr_error),
    .o_addr(o_addr), .o_rd_cmd(o_rd_cmd), .i_busy(i_busy), .i_instr_vld(i_instr_vld),
    .i_instr_dat(i_instr_dat), .i_err_align(i_err_align), .i_err_bus(i_err_bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          ifu_lat = 2;
  int          slow_lat = 8;
  logic [31:0] slow_addr = 32'h1;
  logic [31:0] err_bus_addr = 32'h1;
  logic [31:0] err_align_addr = 32'h1;

  function automatic logic [31:0] dat_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // IFU: accepts the visible command, answers 'lat' cycles later for one cycle.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  always begin
    @(posedge clk); #1;
    i_instr_vld = 1'b0; i_err_bus = 1'b0; i_err_align = 1'b0; i_instr_dat = '0;
    if (!nrst) pend = 1'b0;
    else begin
      if (pend) begin
        if (cnt <= 1) begin
          i_instr_vld = 1'b1;
          i_instr_dat = dat_of(paddr);
          i_err_bus   = (paddr == err_bus_addr);
          i_err_align = (paddr == err_align_addr);
          pend = 1'b0;
        end else cnt--;
      end
      if (o_rd_cmd) begin
        pend  = 1'b1;
        paddr = o_addr;
        cnt   = (o_addr == slow_addr) ? slow_lat : ifu_lat;
      end
    end
  end

  int          cyc = 0;
  logic [31:0] cmd_addr[$];
  int          cmd_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_dat[$];
  int          pop_cyc[$];
  int          rsp_cyc[$];
  int          bus_err_n = 0;
  int          addr_err_n = 0;

  always @(negedge clk) begin
    cyc++;
    if (nrst) begin
      if (o_rd_cmd) begin cmd_addr.push_back(o_addr); cmd_cyc.push_back(cyc); end
      if (o_instr_vld && i_instr_rdy) begin
        pop_pc.push_back(o_instr_pc); pop_dat.push_back(o_instr); pop_cyc.push_back(cyc);
      end
      if (i_instr_vld) rsp_cyc.push_back(cyc);
      bus_err_n  += int'(o_bus_error);
      addr_err_n += int'(o_addr_error);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    cmd_addr.delete(); cmd_cyc.delete(); pop_pc.delete(); pop_dat.delete();
    pop_cyc.delete(); rsp_cyc.delete(); bus_err_n = 0; addr_err_n = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    nrst = 1'b0; i_jump_valid = 1'b0; i_instr_rdy = 1'b0; i_busy = 1'b0;
    ifu_lat = 2; slow_addr = 32'h1; err_bus_addr = 32'h1; err_align_addr = 32'h1;
    step(2);
    nrst = 1'b1;
    clear_mon();
  endtask

  task automatic do_jump(input logic [31:0] a);
    i_jump_valid = 1'b1; i_jump_addr = a;
    step(1);
    i_jump_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; i_jump_valid = 1'b0; i_jump_addr = '0; i_instr_rdy = 1'b0; i_busy = 1'b0;
    #2;
    checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want %h", o_addr, 32'h0); end
    checks++; if (o_rd_cmd !== 1'b0) begin errors++; $display("FAIL rst_rd_cmd: got %b want 0", o_rd_cmd); end
    checks++; if (o_instr_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", o_instr_vld); end
    checks++; if (o_instr !== NOP_V) begin errors++; $display("FAIL rst_instr: got %h want %h", o_instr, NOP_V); end
    checks++; if (o_instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", o_instr_pc); end
    checks++; if (o_bus_error !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b want 0", o_bus_error); end
    checks++; if (o_addr_error !== 1'b0) begin errors++; $display("FAIL rst_addr_err: got %b want 0", o_addr_error); end
    step(2);
    nrst = 1'b1;
    clear_mon();
  endtask

  task automatic test_sequential();
    do_reset();
    i_instr_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin if (pop_pc.size() >= 3) break; step(1); end
    checks++; if (pop_pc.size() < 3) begin errors++; $display("FAIL seq_timeout: got %0d pops want 3", pop_pc.size()); end
    if (pop_pc.size() >= 3 && cmd_addr.size() >= 3) begin
      for (int unsigned i = 0; i < 3; i++) begin
        checks++; if (cmd_addr[i] !== 32'h100 + 4*i) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, cmd_addr[i], 32'h100 + 4*i); end
        checks++; if (pop_pc[i] !== 32'h100 + 4*i) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pop_pc[i], 32'h100 + 4*i); end
        checks++; if (pop_dat[i] !== dat_of(32'h100 + 4*i)) begin errors++; $display("FAIL seq_dat%0d: got %h want %h", i, pop_dat[i], dat_of(32'h100 + 4*i)); end
      end
      checks++; if (cmd_cyc[1] - cmd_cyc[0] != 4) begin errors++; $display("FAIL seq_interval: got %0d want 4", cmd_cyc[1] - cmd_cyc[0]); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    i_instr_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin if (pop_cyc.size() >= 1) break; step(1); end
    checks++; if (pop_cyc.size() < 1 || rsp_cyc.size() < 1) begin errors++; $display("FAIL lat_timeout: got %0d pops want 1", pop_cyc.size()); end
    else begin
`ifdef FETCH_PFQ_BYPASS_EN
      checks++; if (pop_cyc[0] != rsp_cyc[0]) begin errors++; $display("FAIL lat_bypass: got vld cycle %0d want %0d", pop_cyc[0], rsp_cyc[0]); end
`else
      checks++; if (pop_cyc[0] != rsp_cyc[0] + 1) begin errors++; $display("FAIL lat_reg: got vld cycle %0d want %0d", pop_cyc[0], rsp_cyc[0] + 1); end
`endif
      checks++; if (pop_pc[0] !== 32'h100) begin errors++; $display("FAIL lat_pc: got %h want 100", pop_pc[0]); end
    end
  endtask

  task automatic test_busy();
    do_reset();
    i_busy = 1'b1; i_instr_rdy = 1'b1;
    step(10);
    checks++; if (cmd_addr.size() != 0) begin errors++; $display("FAIL busy_hold: got %0d cmds want 0", cmd_addr.size()); end
    i_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin if (cmd_addr.size() >= 1) break; step(1); end
    checks++; if (cmd_addr.size() < 1 || cmd_addr[0] !== 32'h100) begin errors++; $display("FAIL busy_release: got %0d cmds want first at 100", cmd_addr.size()); end
  endtask

  task automatic test_fill();
    do_reset();
    step(40);
    checks++; if (cmd_addr.size() != 4) begin errors++; $display("FAIL fill_cmds: got %0d want 4", cmd_addr.size()); end
    checks++; if (cmd_addr.size() < 4 || cmd_addr[3] !== 32'h10C) begin errors++; $display("FAIL fill_last: got %0d cmds want last 10c", cmd_addr.size()); end
    checks++; if (o_instr_vld !== 1'b1) begin errors++; $display("FAIL fill_vld: got %b want 1", o_instr_vld); end
    checks++; if (o_instr_pc !== 32'h100) begin errors++; $display("FAIL fill_head_pc: got %h want 100", o_instr_pc); end
    checks++; if (o_instr !== dat_of(32'h100)) begin errors++; $display("FAIL fill_head_dat: got %h want %h", o_instr, dat_of(32'h100)); end
    clear_mon();
    i_instr_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin if (pop_pc.size() >= 4 && cmd_addr.size() >= 1) break; step(1); end
    checks++; if (pop_pc.size() < 4 || cmd_addr.size() < 1) begin errors++; $display("FAIL drain_timeout: got %0d pops want 4", pop_pc.size()); end
    else begin
      for (int unsigned i = 0; i < 4; i++) begin
        checks++; if (pop_pc[i] !== 32'h100 + 4*i) begin errors++; $display("FAIL drain_pc%0d: got %h want %h", i, pop_pc[i], 32'h100 + 4*i); end
      end
      checks++; if (cmd_addr[0] !== 32'h110) begin errors++; $display("FAIL resume_addr: got %h want 110", cmd_addr[0]); end
      checks++; if (cmd_cyc[0] != pop_cyc[0] + 2) begin errors++; $display("FAIL resume_time: got %0d want %0d", cmd_cyc[0], pop_cyc[0] + 2); end
    end
  endtask

  task automatic test_jump_drop();
    int bad;
    do_reset();
    slow_addr = 32'h10C;
    for (int k = 0; k < 40; k++) begin if (cmd_addr.size() >= 4) break; step(1); end
    checks++; if (cmd_addr.size() < 4 || cmd_addr[3] !== 32'h10C) begin errors++; $display("FAIL jd_setup: got %0d cmds want 4th at 10c", cmd_addr.size()); end
    step(2);
    do_jump(32'h2000);
    checks++; if (o_instr_vld !== 1'b0) begin errors++; $display("FAIL jd_flush_vld: got %b want 0", o_instr_vld); end
    i_instr_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin if (pop_pc.size() >= 2) break; step(1); end
    checks++; if (pop_pc.size() < 2 || cmd_addr.size() < 5 || rsp_cyc.size() < 4) begin errors++; $display("FAIL jd_timeout: got %0d pops want 2", pop_pc.size()); end
    else begin
      checks++; if (cmd_addr[4] !== 32'h2000) begin errors++; $display("FAIL jd_target: got %h want 2000", cmd_addr[4]); end
      checks++; if (cmd_cyc[4] != rsp_cyc[3] + 2) begin errors++; $display("FAIL jd_wait_drop: got %0d want %0d", cmd_cyc[4], rsp_cyc[3] + 2); end
      checks++; if (pop_pc[0] !== 32'h2000) begin errors++; $display("FAIL jd_first_pc: got %h want 2000", pop_pc[0]); end
      checks++; if (pop_dat[0] !== dat_of(32'h2000)) begin errors++; $display("FAIL jd_first_dat: got %h want %h", pop_dat[0], dat_of(32'h2000)); end
      bad = 0;
      foreach (pop_dat[i]) if (pop_dat[i] === dat_of(32'h10C) || pop_pc[i] === 32'h10C) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL jd_no_stale: got %0d stale pops want 0", bad); end
    end
  endtask

  task automatic test_errors();
    do_reset();
    err_bus_addr = 32'h108;
    step(40);
    checks++; if (cmd_addr.size() != 3) begin errors++; $display("FAIL be_cmds: got %0d want 3", cmd_addr.size()); end
    checks++; if (bus_err_n != 1) begin errors++; $display("FAIL be_pulse: got %0d want 1", bus_err_n); end
    checks++; if (addr_err_n != 0) begin errors++; $display("FAIL be_no_align: got %0d want 0", addr_err_n); end
    checks++; if (o_instr_pc !== 32'h100) begin errors++; $display("FAIL be_head: got %h want 100", o_instr_pc); end
    i_instr_rdy = 1'b1;
    step(10);
    checks++; if (pop_pc.size() != 2) begin errors++; $display("FAIL be_drain_n: got %0d want 2", pop_pc.size()); end
    checks++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104) begin errors++; $display("FAIL be_drain_order: got %0d pops want 100,104", pop_pc.size()); end
    checks++; if (cmd_addr.size() != 3) begin errors++; $display("FAIL be_halted: got %0d cmds want 3", cmd_addr.size()); end
    checks++; if (o_instr !== NOP_V) begin errors++; $display("FAIL be_nop: got %h want %h", o_instr, NOP_V); end
    err_align_addr = 32'h8;
    do_jump(32'h0);
    step(30);
    checks++; if (cmd_addr.size() != 6) begin errors++; $display("FAIL ae_cmds: got %0d want 6", cmd_addr.size()); end
    checks++; if (cmd_addr.size() < 6 || cmd_addr[3] !== 32'h0 || cmd_addr[5] !== 32'h8) begin errors++; $display("FAIL ae_restart: got %0d cmds want 0,4,8", cmd_addr.size()); end
    checks++; if (addr_err_n != 1) begin errors++; $display("FAIL ae_pulse: got %0d want 1", addr_err_n); end
    checks++; if (bus_err_n != 1) begin errors++; $display("FAIL ae_bus_quiet: got %0d want 1", bus_err_n); end
  endtask

  task automatic test_jump_pop_push();
    int bad;
    do_reset();
    for (int k = 0; k < 40; k++) begin if (cmd_addr.size() >= 3) break; step(1); end
    step(1);
    i_jump_valid = 1'b1; i_jump_addr = 32'h3000; i_instr_rdy = 1'b1;
    #2;
    checks++; if (i_instr_vld !== 1'b1) begin errors++; $display("FAIL jpp_setup_rsp: got %b want 1", i_instr_vld); end
    checks++; if (o_instr_vld !== 1'b1) begin errors++; $display("FAIL jpp_setup_head: got %b want 1", o_instr_vld); end
    step(1);
    i_jump_valid = 1'b0; i_instr_rdy = 1'b0;
    checks++; if (o_instr_vld !== 1'b0) begin errors++; $display("FAIL jpp_empty: got %b want 0", o_instr_vld); end
    clear_mon();
    step(40);
    checks++; if (cmd_addr.size() != 4) begin errors++; $display("FAIL jpp_refill: got %0d cmds want 4", cmd_addr.size()); end
    checks++; if (cmd_addr.size() < 4 || cmd_addr[0] !== 32'h3000 || cmd_addr[3] !== 32'h300C) begin errors++; $display("FAIL jpp_addrs: got %0d cmds want 3000..300c", cmd_addr.size()); end
    checks++; if (o_instr_pc !== 32'h3000) begin errors++; $display("FAIL jpp_head: got %h want 3000", o_instr_pc); end
    i_instr_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin if (pop_pc.size() >= 4) break; step(1); end
    checks++; if (pop_pc.size() < 4) begin errors++; $display("FAIL jpp_timeout: got %0d pops want 4", pop_pc.size()); end
    else begin
      bad = 0;
      for (int unsigned i = 0; i < 4; i++) if (pop_pc[i] !== 32'h3000 + 4*i || pop_dat[i] !== dat_of(32'h3000 + 4*i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL jpp_order: got %0d wrong pops want 0", bad); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    i_instr_rdy = 1'b1;
    do_jump(32'hFFFF_FFF8);
    clear_mon();
    for (int k = 0; k < 40; k++) begin if (pop_pc.size() >= 3) break; step(1); end
    checks++; if (pop_pc.size() < 3 || cmd_addr.size() < 3) begin errors++; $display("FAIL wrap_timeout: got %0d pops want 3", pop_pc.size()); end
    else begin
      checks++; if (cmd_addr[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffc", cmd_addr[1]); end
      checks++; if (cmd_addr[2] !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", cmd_addr[2]); end
      checks++; if (pop_pc[2] !== 32'h0 || pop_dat[2] !== dat_of(32'h0)) begin errors++; $display("FAIL wrap_pop: got %h/%h want 0/%h", pop_pc[2], pop_dat[2], dat_of(32'h0)); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_busy();
    test_fill();
    test_jump_drop();
    test_errors();
    test_jump_pop_push();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
